// File: rtl/edge_trigger_pkg.sv
// -----------------------------------------------------------------------------
// edge_trigger_pkg
// Shared constants for the multi-channel edge trigger:
//   - FSM state encodings (IDLE, COUNT, HOLDOFF, DONE)
//   - edge-mode encodings for cfg_edge_mode
// -----------------------------------------------------------------------------
package edge_trigger_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COUNT   = 2'd1;
    localparam logic [1:0] ST_HOLDOFF = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [1:0] EDGE_RISE  = 2'd0;
    localparam logic [1:0] EDGE_FALL  = 2'd1;
    localparam logic [1:0] EDGE_BOTH  = 2'd2;
    localparam logic [1:0] EDGE_RSVD  = 2'd3;  // behaves as EDGE_BOTH

endpackage

// File: rtl/edge_detect_ch.sv
// -----------------------------------------------------------------------------
// edge_detect_ch
// One trigger channel: 2-flop synchroniser, history flop, edge qualification.
// Ports:
//   clk, rst_n   - sample clock, async active-low reset
//   din          - asynchronous trigger source
//   edge_mode    - rising / falling / both (reserved = both)
//   edge_det     - combinational qualified edge for the current cycle
// -----------------------------------------------------------------------------
module edge_detect_ch
    import edge_trigger_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic [1:0] edge_mode,
    output logic       edge_det
);

    logic       sync1, sync2, hist;
    // Marks when hist holds a genuinely sampled value, so the reset-to-real
    // transition of the flops is never mistaken for an input edge.
    logic [2:0] vld_pipe;
    logic       rise, fall, qual;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            hist     <= 1'b0;
            vld_pipe <= '0;
        end else begin
            sync1    <= din;
            sync2    <= sync1;
            hist     <= sync2;
            vld_pipe <= {vld_pipe[1:0], 1'b1};
        end
    end

    assign rise = sync2 & ~hist;
    assign fall = ~sync2 & hist;

    always_comb begin
        qual = 1'b0;
        case (edge_mode)
            EDGE_RISE: qual = rise;
            EDGE_FALL: qual = fall;
            default:   qual = rise | fall;
        endcase
    end

    assign edge_det = vld_pipe[2] & qual;

endmodule

// File: rtl/edge_trigger_multi.sv
// -----------------------------------------------------------------------------
// edge_trigger_multi
// Counts qualified edges across a masked set of channels and issues a
// single-cycle trigger on event number cfg_edge_count+1 of a run.
// Optional feature macro: EDGE_TRIGGER_HOLDOFF_EN -- re-arm after a holdoff
// window instead of parking in DONE.
// Ports:
//   adc_sampleclk, reset_n        - clock, async active-low reset
//   trigger_in[pCHANNELS]         - asynchronous trigger sources
//   armed_and_ready, active       - run enable (both must be high)
//   cfg_channel_mask/edge_mode/edge_count/holdoff - latched at run start
//   trigger                       - one-cycle trigger pulse
//   edge_counter                  - events counted in current/last search
//   trig_count                    - triggers in current/last run (sat. 255)
//   busy                          - FSM not in IDLE
// -----------------------------------------------------------------------------
module edge_trigger_multi
    import edge_trigger_pkg::*;
#(
    parameter int pCHANNELS      = 4,
    parameter int pCOUNT_WIDTH   = 16,
    parameter int pHOLDOFF_WIDTH = 16
) (
    input  logic                      adc_sampleclk,
    input  logic                      reset_n,
    input  logic [pCHANNELS-1:0]      trigger_in,
    input  logic                      armed_and_ready,
    input  logic                      active,
    input  logic [pCHANNELS-1:0]      cfg_channel_mask,
    input  logic [1:0]                cfg_edge_mode,
    input  logic [pCOUNT_WIDTH-1:0]   cfg_edge_count,
    input  logic [pHOLDOFF_WIDTH-1:0] cfg_holdoff,
    output logic                      trigger,
    output logic [pCOUNT_WIDTH-1:0]   edge_counter,
    output logic [7:0]                trig_count,
    output logic                      busy
);

    logic                    running, running_r;
    logic [1:0]              state;
    logic [pCHANNELS-1:0]    lat_mask;
    logic [1:0]              lat_mode;
    logic [pCOUNT_WIDTH-1:0] lat_count;
    logic [pCHANNELS-1:0]    ch_edge;
    logic                    event_hit;

`ifdef EDGE_TRIGGER_HOLDOFF_EN
    logic [pHOLDOFF_WIDTH-1:0] lat_holdoff;
    logic [pHOLDOFF_WIDTH-1:0] holdoff_cnt;
`else
    logic unused_holdoff;
    assign unused_holdoff = ^cfg_holdoff;
`endif

    assign running = active & armed_and_ready;

    // Qualification uses the latched mode so mid-run cfg changes are inert.
    for (genvar gi = 0; gi < pCHANNELS; gi++) begin : g_ch
        edge_detect_ch u_ch (
            .clk       (adc_sampleclk),
            .rst_n     (reset_n),
            .din       (trigger_in[gi]),
            .edge_mode (lat_mode),
            .edge_det  (ch_edge[gi])
        );
    end

    // Simultaneous channel edges collapse into a single event.
    assign event_hit = |(ch_edge & lat_mask);

    always_ff @(posedge adc_sampleclk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            running_r    <= 1'b0;
            trigger      <= 1'b0;
            edge_counter <= '0;
            trig_count   <= '0;
            lat_mask     <= '0;
            lat_mode     <= '0;
            lat_count    <= '0;
`ifdef EDGE_TRIGGER_HOLDOFF_EN
            lat_holdoff  <= '0;
            holdoff_cnt  <= '0;
`endif
        end else begin
            running_r <= running;
            trigger   <= 1'b0;
            // Losing run enable wins over everything, including a trigger
            // that would otherwise fire this cycle.
            if (!running) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (!running_r) begin
                            state        <= ST_COUNT;
                            edge_counter <= '0;
                            trig_count   <= '0;
                            lat_mask     <= cfg_channel_mask;
                            lat_mode     <= cfg_edge_mode;
                            lat_count    <= cfg_edge_count;
`ifdef EDGE_TRIGGER_HOLDOFF_EN
                            lat_holdoff  <= cfg_holdoff;
`endif
                        end
                    end
                    ST_COUNT: begin
                        if (event_hit) begin
                            if (edge_counter != '1)
                                edge_counter <= edge_counter + pCOUNT_WIDTH'(1);
                            if (edge_counter == lat_count) begin
                                trigger <= 1'b1;
                                if (trig_count != 8'hFF)
                                    trig_count <= trig_count + 8'd1;
`ifdef EDGE_TRIGGER_HOLDOFF_EN
                                state       <= ST_HOLDOFF;
                                holdoff_cnt <= lat_holdoff;
`else
                                state       <= ST_DONE;
`endif
                            end
                        end
                    end
`ifdef EDGE_TRIGGER_HOLDOFF_EN
                    // Window length is max(holdoff, 1) cycles.
                    ST_HOLDOFF: begin
                        if (holdoff_cnt <= pHOLDOFF_WIDTH'(1)) begin
                            state        <= ST_COUNT;
                            edge_counter <= '0;
                        end else begin
                            holdoff_cnt <= holdoff_cnt - pHOLDOFF_WIDTH'(1);
                        end
                    end
`endif
                    default: ;  // DONE: park until running drops
                endcase
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_edge_trigger_multi.sv
// -----------------------------------------------------------------------------
// tb_edge_trigger_multi
// Directed bench for edge_trigger_multi (default parameters). Inputs change
// 1 time unit after a rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_edge_trigger_multi;

    logic        clk;
    logic        reset_n;
    logic [3:0]  trigger_in;
    logic        armed_and_ready;
    logic        active;
    logic [3:0]  cfg_channel_mask;
    logic [1:0]  cfg_edge_mode;
    logic [15:0] cfg_edge_count;
    logic [15:0] cfg_holdoff;
    logic        trigger;
    logic [15:0] edge_counter;
    logic [7:0]  trig_count;
    logic        busy;

    int checks = 0;
    int fails  = 0;

    edge_trigger_multi dut (
        .adc_sampleclk    (clk),
        .reset_n          (reset_n),
        .trigger_in       (trigger_in),
        .armed_and_ready  (armed_and_ready),
        .active           (active),
        .cfg_channel_mask (cfg_channel_mask),
        .cfg_edge_mode    (cfg_edge_mode),
        .cfg_edge_count   (cfg_edge_count),
        .cfg_holdoff      (cfg_holdoff),
        .trigger          (trigger),
        .edge_counter     (edge_counter),
        .trig_count       (trig_count),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [3:0] tog [5];
    logic [31:0] ec_after5;

    initial begin
        tog[0] = 4'b0000; tog[1] = 4'b0010; tog[2] = 4'b0011;
        tog[3] = 4'b0001; tog[4] = 4'b0000;
`ifdef EDGE_TRIGGER_HOLDOFF_EN
        ec_after5 = 32'd1;
`else
        ec_after5 = 32'd4;
`endif

        // ---- reset state, input high through reset ----
        reset_n          = 1'b0;
        trigger_in       = 4'b0001;
        armed_and_ready  = 1'b1;
        active           = 1'b1;
        cfg_channel_mask = 4'b0001;
        cfg_edge_mode    = 2'd0;
        cfg_edge_count   = 16'd0;
        cfg_holdoff      = 16'd0;
        #12;
        check("rst_trigger", 32'(trigger), 0);
        check("rst_edge_counter", 32'(edge_counter), 0);
        check("rst_trig_count", 32'(trig_count), 0);
        check("rst_busy", 32'(busy), 0);

        // Release with trigger_in high: run starts, no spurious event.
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("rel_busy", 32'(busy), 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rel_no_trigger", 32'(trigger), 0);
        end
        check("rel_edge_counter", 32'(edge_counter), 0);

        // ---- single rising edge, count 0: latency k+2 ----
        active = 1'b0;
        tick();
        check("t1_idle", 32'(busy), 0);
        trigger_in = 4'b0000;
        ticks(3);
        active = 1'b1;
        tick();
        check("t1_busy", 32'(busy), 1);
        trigger_in = 4'b0001;
        ticks(2);
        check("t1_trig_early", 32'(trigger), 0);
        tick();
        check("t1_trig", 32'(trigger), 1);
        check("t1_edge_counter", 32'(edge_counter), 1);
        check("t1_trig_count", 32'(trig_count), 1);
        tick();
        check("t1_trig_pulse", 32'(trigger), 0);

        // ---- both edges, count 3, alternating ch0/ch1 ----
        active = 1'b0;
        tick();
        check("t2_idle", 32'(busy), 0);
        check("t2_ec_retained", 32'(edge_counter), 1);
        check("t2_tc_retained", 32'(trig_count), 1);
        cfg_edge_count   = 16'd3;
        cfg_edge_mode    = 2'd2;
        cfg_channel_mask = 4'b0011;
        ticks(3);
        active = 1'b1;
        tick();
        check("t2_ec_clear", 32'(edge_counter), 0);
        check("t2_tc_clear", 32'(trig_count), 0);
        for (int i = 0; i < 4; i++) begin
            trigger_in = tog[i];
            ticks(2);
            check("t2_trig_early", 32'(trigger), 0);
            tick();
            check("t2_trig", 32'(trigger), (i == 3) ? 32'd1 : 32'd0);
            check("t2_edge_counter", 32'(edge_counter), 32'(i + 1));
        end
        check("t2_trig_count", 32'(trig_count), 1);
        tick();
        check("t2_trig_pulse", 32'(trigger), 0);
        trigger_in = tog[4];
        ticks(3);
        check("t2_fifth_no_trig", 32'(trigger), 0);
        check("t2_fifth_ec", 32'(edge_counter), ec_after5);
        check("t2_fifth_tc", 32'(trig_count), 1);

        // ---- simultaneous edges; mid-run cfg change has no effect ----
        active = 1'b0;
        tick();
        cfg_channel_mask = 4'b0101;
        cfg_edge_count   = 16'd1;
        cfg_edge_mode    = 2'd0;
        trigger_in       = 4'b0000;
        ticks(3);
        active = 1'b1;
        tick();
        cfg_edge_count   = 16'd0;
        cfg_channel_mask = 4'b1111;
        cfg_edge_mode    = 2'd2;
        trigger_in = 4'b0101;
        ticks(3);
        check("t3_simul_ec", 32'(edge_counter), 1);
        check("t3_simul_no_trig", 32'(trigger), 0);
        trigger_in = 4'b0000;
        ticks(3);
        check("t3_fall_ignored", 32'(edge_counter), 1);
        check("t3_fall_no_trig", 32'(trigger), 0);
        trigger_in = 4'b0100;
        ticks(2);
        check("t3_trig_early", 32'(trigger), 0);
        tick();
        check("t3_trig", 32'(trigger), 1);
        check("t3_edge_counter", 32'(edge_counter), 2);

        // ---- active drops just before qualifying edge ----
        active = 1'b0;
        tick();
        cfg_channel_mask = 4'b0001;
        cfg_edge_count   = 16'd1;
        cfg_edge_mode    = 2'd0;
        trigger_in       = 4'b0000;
        ticks(3);
        active = 1'b1;
        tick();
        trigger_in = 4'b0001;
        ticks(3);
        check("t4_first_ec", 32'(edge_counter), 1);
        check("t4_first_no_trig", 32'(trigger), 0);
        trigger_in = 4'b0000;
        ticks(3);
        trigger_in = 4'b0001;
        ticks(2);
        active = 1'b0;
        tick();
        check("t4_suppressed", 32'(trigger), 0);
        check("t4_idle", 32'(busy), 0);
        check("t4_ec_hold", 32'(edge_counter), 1);
        tick();
        check("t4_still_no_trig", 32'(trigger), 0);

        // ---- async reset in the middle of COUNT ----
        active = 1'b1;
        tick();
        check("t5_ec_clear", 32'(edge_counter), 0);
        trigger_in = 4'b0000;
        ticks(3);
        trigger_in = 4'b0001;
        ticks(3);
        check("t5_ec_pre", 32'(edge_counter), 1);
        check("t5_busy_pre", 32'(busy), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_rst_trigger", 32'(trigger), 0);
        check("t5_rst_ec", 32'(edge_counter), 0);
        check("t5_rst_tc", 32'(trig_count), 0);
        check("t5_rst_busy", 32'(busy), 0);

`ifdef EDGE_TRIGGER_HOLDOFF_EN
        // ---- holdoff window: rising edge every 4 cycles, holdoff 10 ----
        active           = 1'b0;
        trigger_in       = 4'b0000;
        cfg_channel_mask = 4'b0001;
        cfg_edge_mode    = 2'd0;
        cfg_edge_count   = 16'd0;
        cfg_holdoff      = 16'd10;
        @(negedge clk);
        reset_n = 1'b1;
        ticks(4);
        active = 1'b1;
        tick();
        for (int s = 0; s < 30; s++) begin
            trigger_in = ((s % 4) < 2) ? 4'b0001 : 4'b0000;
            tick();
            check("t6_holdoff_trig", 32'(trigger),
                  (s + 1 == 3 || s + 1 == 15 || s + 1 == 27) ? 32'd1 : 32'd0);
        end
        check("t6_trig_count", 32'(trig_count), 3);
`endif

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/edge_trigger_multi.md
EDGE_TRIGGER_MULTI -- requirements
Module: edge_trigger_multi

Interface
REQ-001 SHALL have parameter pCHANNELS, default 4, number of trigger input channels (1..16).
REQ-002 SHALL have parameter pCOUNT_WIDTH, default 16, width of the edge count and edge counter.
REQ-003 SHALL have parameter pHOLDOFF_WIDTH, default 16, width of the holdoff counter.
REQ-004 SHALL have port adc_sampleclk  input  1  sole clock; one clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port trigger_in  input  pCHANNELS  asynchronous trigger sources.
REQ-007 SHALL have ports armed_and_ready, active  input  1 each; running = active AND armed_and_ready.
REQ-008 SHALL have port cfg_channel_mask  input  pCHANNELS  1 = channel participates.
REQ-009 SHALL have port cfg_edge_mode  input  2  0 rising, 1 falling, 2 both, 3 reserved (treated as both).
REQ-010 SHALL have port cfg_edge_count  input  pCOUNT_WIDTH  trigger on event number cfg_edge_count+1.
REQ-011 SHALL have port cfg_holdoff  input  pHOLDOFF_WIDTH  holdoff cycles between triggers.
REQ-012 SHALL have port trigger  output  1  single-cycle trigger pulse.
REQ-013 SHALL have port edge_counter  output  pCOUNT_WIDTH  events counted in current/last search.
REQ-014 SHALL have port trig_count  output  8  triggers issued in current/last run.
REQ-015 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-016 Each channel SHALL pass through a 2-flop synchroniser then a history flop; edge qualified by cfg_edge_mode.
REQ-017 Event SHALL be the OR of qualified, masked channel edges in a cycle; simultaneous edges on several channels count once.
REQ-018 FSM states SHALL be IDLE, COUNT, HOLDOFF, DONE.
REQ-019 IDLE->COUNT on the cycle running rises (registered running_r low, running high): clear edge_counter and trig_count, latch all cfg_* inputs; events in that cycle ignored.
REQ-020 In COUNT, each event SHALL increment edge_counter by 1; if edge_counter equals latched count at that event, assert trigger next cycle and leave COUNT.
REQ-021 edge_counter SHALL saturate at all-ones, never wrap; saturating does not itself trigger.
REQ-022 Latency: trigger_in change first sampled at edge k SHALL produce trigger high in the cycle following edge k+2.
REQ-023 trigger SHALL be high exactly one cycle per trigger event.
REQ-024 trig_count SHALL increment per trigger, saturating at 255.
REQ-025 running low in any state SHALL force IDLE next cycle; edge_counter and trig_count retain values; a pending trigger is suppressed.
REQ-026 Latched mask of zero SHALL never trigger; block stays in COUNT until running drops.
REQ-027 Configuration changes during a run SHALL have no effect until the next IDLE->COUNT transition.

Reset
REQ-028 reset_n low SHALL asynchronously force IDLE, trigger=0, edge_counter=0, trig_count=0, busy=0, all synchroniser/history flops 0, latched config 0.
REQ-029 Release of reset_n SHALL not generate an event or trigger, even if trigger_in is high.

Configuration
REQ-030 Macro EDGE_TRIGGER_HOLDOFF_EN defined: after a trigger, COUNT->HOLDOFF for latched cfg_holdoff cycles (0 = one cycle), then HOLDOFF->COUNT with edge_counter cleared; events during HOLDOFF ignored; repeats until running drops.
REQ-031 Macro undefined: after a trigger, COUNT->DONE; DONE held until running drops; cfg_holdoff ignored; HOLDOFF state and counter absent.

Structure
REQ-032 Package edge_trigger_pkg SHALL hold the FSM state enumeration and the edge-mode constants.
REQ-033 Per-channel synchroniser plus edge qualification SHALL be sub-module edge_detect_ch, instantiated pCHANNELS times.

Verification
REQ-034 cfg_edge_count=0, mode rising, mask=0001; run start, one rising edge ch0 sampled at edge k -> trigger high after edge k+2 for one cycle, edge_counter=1.
REQ-035 cfg_edge_count=3, mode both, mask=0011; 4 toggles alternating ch0/ch1 -> one trigger on 4th toggle, trig_count=1, none on a 5th toggle (macro undefined).
REQ-036 Simultaneous rising edges ch0 and ch2, mask=0101, count=1 -> edge_counter increments by 1; trigger only on a second event cycle.
REQ-037 Macro defined, count=0, holdoff=10, rising edges every 4 cycles -> triggers spaced by holdoff window, edges within holdoff ignored, trig_count increments each trigger.
REQ-038 active dropped one cycle before qualifying edge -> no trigger, state IDLE, edge_counter holds value; reset_n asserted mid-COUNT -> all outputs 0 immediately.
